// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: shared types and constants for the SPI bus arbiter and its requesters
package spi_arb_pkg;
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, GAP} arb_state_t;
  localparam int CMD_W = 16;
  localparam int GAP_CYC_DEF = 4;
  localparam int TO_CYC_DEF = 4096;
  localparam logic [15:0] IMU_WHO_AM_I = 16'h8F00;
  localparam logic [15:0] IMU_INIT = 16'h0D02;
  localparam logic [15:0] IMU_YAW_RD = 16'hA400;
  localparam logic [15:0] A2D_BATT = 16'h2800;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin scan starting just after the last owner
module rr_picker #(
  parameter int N = 2,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] win,
  output logic          valid
);
  logic [IW-1:0] idx;
  always_comb begin
    win = last;
    idx = '0;
    for (int k = N; k >= 1; k--) begin
      idx = IW'((int'(last) + k) % N);
      if (req[idx]) win = idx;
    end
  end
  assign valid = |req;
endmodule

// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: round-robin sequencer sharing one SPI master between requesters,
// with an enforced idle gap and a watchdog that aborts stuck transactions.
module spi_bus_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int CMD_W = spi_arb_pkg::CMD_W,
  parameter int GAP_CYC = spi_arb_pkg::GAP_CYC_DEF,
  parameter int TO_CYC = spi_arb_pkg::TO_CYC_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CMD_W-1:0] cmd_in,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       rdy,
  output logic [CMD_W-1:0]         resp_out,
  output logic                     err,
  output logic                     busy,
  output logic                     spi_snd,
  output logic [CMD_W-1:0]         spi_cmd,
  input  logic                     spi_done,
  input  logic [CMD_W-1:0]         spi_resp
);
  import spi_arb_pkg::*;
  localparam int IW = $clog2(NUM_REQ);
  localparam int GW = GAP_CYC > 0 ? $clog2(GAP_CYC + 1) : 1;
  localparam int WW = $clog2(TO_CYC + 1);
  arb_state_t state, state_n;
  logic [IW-1:0] owner, last_owner, win;
  logic any_req, done_prev, done_edge, wd_exp, finish;
  logic [GW-1:0] gap;
  logic [WW-1:0] wd;
  rr_picker #(.N(NUM_REQ)) u_pick (
    .req  (req),
    .last (last_owner),
    .win  (win),
    .valid(any_req)
  );
  assign done_edge = spi_done & ~done_prev;
  assign wd_exp = wd == WW'(TO_CYC - 1);
  assign finish = done_edge | wd_exp;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = any_req ? LAUNCH : IDLE;
      LAUNCH:  state_n = WAIT;
      WAIT:    state_n = finish ? GAP : WAIT;
      GAP:     state_n = gap == '0 ? IDLE : GAP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt <= '0;
      rdy <= '0;
      err <= 1'b0;
      busy <= 1'b0;
      spi_snd <= 1'b0;
      spi_cmd <= '0;
      resp_out <= '0;
      owner <= '0;
      last_owner <= IW'(NUM_REQ - 1);
      gap <= '0;
      wd <= '0;
      done_prev <= 1'b0;
    end else begin
      done_prev <= spi_done;
      rdy <= '0;
      err <= 1'b0;
      spi_snd <= 1'b0;
      busy <= state_n != IDLE;
      if (state == IDLE && any_req) begin
        owner <= win;
        gnt <= NUM_REQ'(1) << win;
        spi_cmd <= cmd_in[win*CMD_W +: CMD_W];
      end
      if (state == LAUNCH) begin
        spi_snd <= 1'b1;
        wd <= '0;
      end
      // a done edge on the expiry cycle still counts as a normal completion
      if (state == WAIT) begin
        wd <= wd + 1'b1;
        if (finish) begin
          resp_out <= done_edge ? spi_resp : '0;
          err <= ~done_edge;
          rdy <= NUM_REQ'(1) << owner;
          last_owner <= owner;
          gnt <= '0;
          gap <= GW'(GAP_CYC);
        end
      end
      if (state == GAP && gap != '0) gap <= gap - 1'b1;
    end
  end
endmodule

// File: tb/tb_spi_bus_arbiter.sv
// tb_spi_bus_arbiter: directed scoreboard bench; an SPI slave model predicts each
// completion at spi_snd and a decoupled monitor checks every rdy against it.
module tb_spi_bus_arbiter;
  localparam int TO = 64;
  localparam int K_NORM = 0, K_TO = 1, K_ABORT = 2;
  typedef struct {
    int owner;
    logic [15:0] cmd;
    logic [15:0] resp;
    int dly;
    int kind;
    int snd_at;
    bit hold;
  } tx_t;
  typedef struct {
    logic [1:0] rdy;
    logic [15:0] resp;
    logic err;
    logic [15:0] cmd;
    int at;
  } sb_t;
  logic clk = 0, rst = 1;
  logic [1:0] req, gnt, rdy;
  logic [31:0] cmd_in = '0;
  logic [15:0] resp_out, spi_cmd, spi_resp = '0;
  logic err, busy, spi_snd, spi_done = 0;
  int cyc = 0, last_rdy = 0, total = 0, passed = 0;
  int issued[2] = '{0, 0};
  int served[2] = '{0, 0};
  tx_t txq[$];
  sb_t sbq[$];
  tx_t t;
  sb_t e;
  spi_bus_arbiter #(.NUM_REQ(2), .CMD_W(16), .GAP_CYC(4), .TO_CYC(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .cmd_in(cmd_in), .gnt(gnt), .rdy(rdy),
    .resp_out(resp_out), .err(err), .busy(busy), .spi_snd(spi_snd),
    .spi_cmd(spi_cmd), .spi_done(spi_done), .spi_resp(spi_resp)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign req = {issued[1] > served[1], issued[0] > served[0]};
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
  endtask
  task automatic push(int o, logic [15:0] cmd, logic [15:0] rsp, int dly, int kind, int snd_at, bit hold);
    txq.push_back('{o, cmd, rsp, dly, kind, snd_at, hold});
  endtask
  task automatic wait_done();
    int n = 0;
    while ((txq.size() != 0 || sbq.size() != 0 || busy || req != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      total++;
      $display("FAIL wait_done: timed out with %0d tx and %0d responses pending", txq.size(), sbq.size());
    end
    repeat (2) @(posedge clk);
  endtask
  // slave model: checks each launch and predicts its completion
  initial begin : slave
    forever begin
      @(negedge clk);
      if (!rst && spi_snd) begin
        if (txq.size() == 0) chk("snd_unexpected", 32'(spi_snd), 0);
        else begin
          t = txq.pop_front();
          chk("snd_gnt", 32'(gnt), 32'(1) << t.owner);
          chk("snd_cmd", 32'(spi_cmd), 32'(t.cmd));
          chk("snd_busy", 32'(busy), 1);
          chk("snd_time", cyc, t.snd_at < 0 ? last_rdy + 7 : t.snd_at);
          if (t.kind == K_TO) begin
            spi_resp = 16'hDEAD;
            sbq.push_back('{2'(1 << t.owner), 16'h0000, 1'b1, t.cmd, cyc + TO});
          end else if (t.kind == K_NORM) begin
            sbq.push_back('{2'(1 << t.owner), t.resp, 1'b0, t.cmd, cyc + t.dly + 1});
            for (int k = 1; k <= t.dly; k++) begin
              @(posedge clk);
              #1;
              if (k == t.dly - 1) spi_done = 0;
            end
            spi_done = 1;
            spi_resp = t.resp;
            if (!t.hold) begin
              @(posedge clk);
              #1;
              spi_done = 0;
            end
          end
        end
      end
    end
  end
  always @(negedge clk) begin
    if (!rst) begin
      if (err && rdy == 0) chk("err_without_rdy", 32'(err), 0);
      if (rdy != 0) begin
        last_rdy = cyc;
        for (int i = 0; i < 2; i++) if (rdy[i]) served[i]++;
        if (sbq.size() == 0) chk("rdy_unexpected", 32'(rdy), 0);
        else begin
          e = sbq.pop_front();
          chk("rdy_vec", 32'(rdy), 32'(e.rdy));
          chk("rdy_time", cyc, e.at);
          chk("resp_out", 32'(resp_out), 32'(e.resp));
          chk("err", 32'(err), 32'(e.err));
          chk("spi_cmd_hold", 32'(spi_cmd), 32'(e.cmd));
        end
      end
    end
  end
  initial begin : stim
    int c, n;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_rdy", 32'(rdy), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_snd", 32'(spi_snd), 0);
    chk("rst_cmd", 32'(spi_cmd), 0);
    chk("rst_resp", 32'(resp_out), 0);
    rst = 0;
    @(posedge clk);
    #1;
    c = cyc;
    cmd_in = {16'h1053, 16'h0D02};
    push(0, 16'h0D02, 16'h5A01, 5, K_NORM, c + 2, 0);
    push(1, 16'h1053, 16'h5A02, 7, K_NORM, -1, 0);
    push(0, 16'h0D02, 16'h5A03, 9, K_NORM, -1, 0);
    push(1, 16'h1053, 16'h5A04, 11, K_NORM, -1, 0);
    issued[0] += 2;
    issued[1] += 2;
    wait_done();
    #1;
    c = cyc;
    cmd_in = {16'h1053, 16'hA400};
    push(0, 16'hA400, 16'h00C3, 40, K_NORM, c + 2, 0);
    issued[0]++;
    wait_done();
    #1;
    c = cyc;
    push(1, 16'h1053, 16'h0000, 0, K_TO, c + 2, 0);
    push(0, 16'hA400, 16'h0BEE, 6, K_NORM, -1, 0);
    issued[0]++;
    issued[1]++;
    wait_done();
    #1;
    c = cyc;
    push(1, 16'h1053, 16'h1111, 10, K_NORM, c + 2, 1);
    push(0, 16'hA400, 16'h2222, 20, K_NORM, -1, 0);
    issued[0]++;
    issued[1]++;
    wait_done();
    #1;
    c = cyc;
    push(1, 16'h1053, 16'h3C3C, TO - 1, K_NORM, c + 2, 0);
    issued[1]++;
    wait_done();
    #1;
    c = cyc;
    cmd_in = {16'h2800, 16'hA400};
    push(1, 16'h2800, 16'h4D4D, 30, K_NORM, c + 2, 0);
    issued[1]++;
    repeat (12) @(posedge clk);
    #1;
    issued[1] = served[1];
    wait_done();
    issued[1] = served[1];
    #1;
    c = cyc;
    push(0, 16'hA400, 16'h7777, 8, K_NORM, c + 2, 0);
    push(0, 16'hA400, 16'h0000, 0, K_ABORT, -1, 0);
    issued[0] += 2;
    n = 0;
    while (txq.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      total++;
      $display("FAIL abort_launch: second launch never seen, %0d tx pending", txq.size());
    end
    repeat (10) @(posedge clk);
    #2;
    rst = 1;
    issued[0] = served[0];
    #1;
    chk("mid_rst_gnt", 32'(gnt), 0);
    chk("mid_rst_snd", 32'(spi_snd), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_resp", 32'(resp_out), 0);
    chk("mid_rst_rdy", 32'(rdy), 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    @(posedge clk);
    #1;
    c = cyc;
    cmd_in = {16'h2800, 16'h8F00};
    push(0, 16'h8F00, 16'h0101, 5, K_NORM, c + 2, 0);
    push(1, 16'h2800, 16'h0202, 5, K_NORM, -1, 0);
    issued[0]++;
    issued[1]++;
    wait_done();
    chk("txq_left", txq.size(), 0);
    chk("sbq_left", sbq.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
